// File: rtl/ecc_pkg.sv
// Shared SECDED definitions for the Rx decoder and its bench: widths,
// codeword layout helpers, a reference encoder and the error classes.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_CLEAN = 2'd0,
        ECC_SBE   = 2'd1,
        ECC_DBE   = 2'd2
    } ecc_class_e;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_CW_W   = 128;

    // Smallest p with 2^p >= data_w + p + 1.
    function automatic int calc_pw(input int data_w);
        int p;
        p = 7;
        for (int q = 7; q >= 1; q--) begin
            if ((1 << q) >= data_w + q + 1) p = q;
        end
        return p;
    endfunction

    // Codeword position of data bit k: k-th position >= 3 that is not a power of two.
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < MAX_CW_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k && pos == 0) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Reference encoder; result occupies the low data_w+calc_pw(data_w)+1 bits.
    function automatic logic [MAX_CW_W-1:0] encode(input logic [MAX_DATA_W-1:0] data,
                                                  input int data_w);
        logic [MAX_CW_W-1:0] cw;
        logic                b;
        int                  pw;
        int                  cw_w;
        pw   = calc_pw(data_w);
        cw_w = data_w + pw + 1;
        cw   = '0;
        for (int k = 0; k < data_w; k++) cw[data_pos(k)] = data[k];
        for (int j = 0; j < pw; j++) begin
            b = 1'b0;
            for (int i = 1; i < cw_w; i++) begin
                if (((i >> j) & 1) == 1) b = b ^ cw[i];
            end
            cw[1 << j] = b;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational syndrome (XOR of set-bit indices) and overall parity of a codeword.
module ecc_syndrome_calc
    import ecc_pkg::*;
#(
    parameter int CW_W = 22,
    parameter int P_W  = 5
) (
    input  logic [CW_W-1:0] cw,
    output logic [P_W-1:0]  syn,
    output logic            par
);

    // Fold every set position index into the syndrome; bit 0 only feeds parity.
    always_comb begin
        syn = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw[i]) syn = syn ^ P_W'(i);
        end
        par = ^cw;
    end

endmodule

// File: rtl/ecc_secded_decoder_pipe.sv
// Two-stage SECDED decoder: stage 1 registers syndrome/parity with the payload
// bits, stage 2 classifies, corrects and drives the output beat plus counters.
module ecc_secded_decoder_pipe
    import ecc_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int CNT_W  = 16,
    localparam int P_W    = calc_pw(DATA_W),
    localparam int CW_W   = DATA_W + P_W + 1
) (
    input  logic              i_SCLK,
    input  logic              i_RESETB,
    input  logic              i_VALID,
    output logic              o_READY,
    input  logic [CW_W-1:0]   i_DO,
    input  logic              i_CORR_EN,
    output logic              o_VALID,
    input  logic              i_READY,
    output logic [DATA_W-1:0] o_DO,
    output logic              o_SBE,
    output logic              o_DBE,
    output logic [P_W-1:0]    o_ERR_POS,
    input  logic              i_CNT_CLR,
    output logic [CNT_W-1:0]  o_SBE_CNT,
    output logic [CNT_W-1:0]  o_DBE_CNT
);

    logic              s1_vld;
    logic [DATA_W-1:0] s1_dat;
    logic [P_W-1:0]    s1_syn;
    logic              s1_par;
    logic              s1_corr;

    logic [P_W-1:0]    syn_c;
    logic              par_c;
    logic [DATA_W-1:0] raw_dat;
    logic [DATA_W-1:0] dec_dat;
    ecc_class_e        cls;
    logic              do_fix;
    logic              en2;
    logic              out_xfer;

    ecc_syndrome_calc #(.CW_W(CW_W), .P_W(P_W)) u_syn (
        .cw  (i_DO),
        .syn (syn_c),
        .par (par_c)
    );

    // Check bits are consumed by the syndrome, so only payload positions are carried
    // forward; correction is applied per data bit by matching its position to S.
    for (genvar k = 0; k < DATA_W; k++) begin : g_data
        localparam int POS = data_pos(k);
        assign raw_dat[k] = i_DO[POS];
        assign dec_dat[k] = s1_dat[k] ^ (do_fix & (s1_syn == P_W'(POS)));
    end

    assign en2      = ~o_VALID | i_READY;
    assign o_READY  = ~(s1_vld & o_VALID & ~i_READY);
    assign out_xfer = o_VALID & i_READY;

    // Stage 1: capture the accepted beat; hold everything while globally stalled.
    always_ff @(posedge i_SCLK or negedge i_RESETB) begin
        if (!i_RESETB) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s1_syn  <= '0;
            s1_par  <= 1'b0;
            s1_corr <= 1'b0;
        end else if (o_READY) begin
            s1_vld <= i_VALID;
            if (i_VALID) begin
                s1_dat  <= raw_dat;
                s1_syn  <= syn_c;
                s1_par  <= par_c;
                s1_corr <= i_CORR_EN;
            end
        end
    end

    // Classify the stage-1 beat; a syndrome beyond the last position is uncorrectable.
    always_comb begin
        cls = ECC_CLEAN;
        if (s1_par) begin
            if (int'(s1_syn) > CW_W - 1) cls = ECC_DBE;
            else                         cls = ECC_SBE;
        end else if (s1_syn != '0) begin
            cls = ECC_DBE;
        end
        do_fix = (cls == ECC_SBE) & s1_corr;
    end

    // Stage 2: output register, loaded whenever it is empty or being drained.
    always_ff @(posedge i_SCLK or negedge i_RESETB) begin
        if (!i_RESETB) begin
            o_VALID   <= 1'b0;
            o_DO      <= '0;
            o_SBE     <= 1'b0;
            o_DBE     <= 1'b0;
            o_ERR_POS <= '0;
        end else if (en2) begin
            o_VALID <= s1_vld;
            if (s1_vld) begin
                o_DO      <= dec_dat;
                o_SBE     <= (cls == ECC_SBE);
                o_DBE     <= (cls == ECC_DBE);
                o_ERR_POS <= s1_syn;
            end
        end
    end

    // Saturating error counters, bumped on output transfers; clear wins.
    always_ff @(posedge i_SCLK or negedge i_RESETB) begin
        if (!i_RESETB) begin
            o_SBE_CNT <= '0;
            o_DBE_CNT <= '0;
        end else if (i_CNT_CLR) begin
            o_SBE_CNT <= '0;
            o_DBE_CNT <= '0;
        end else if (out_xfer) begin
            if (o_SBE && !(&o_SBE_CNT)) o_SBE_CNT <= o_SBE_CNT + CNT_W'(1);
            if (o_DBE && !(&o_DBE_CNT)) o_DBE_CNT <= o_DBE_CNT + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ecc_secded_decoder_pipe.sv
// Randomised and directed bench for the SECDED decoder pipe. Expected results
// come from the injected flip set, not from re-decoding the received word.
module tb_ecc_secded_decoder_pipe;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int P_W    = 5;
    localparam int CW_W   = 22;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CW_W-1:0]   mask;
        logic              corr;
    } beat_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sbe;
        logic              dbe;
        logic [P_W-1:0]    pos;
    } res_t;

    logic              i_SCLK = 1'b0;
    logic              i_RESETB = 1'b0;
    logic              i_VALID = 1'b0;
    logic              o_READY;
    logic [CW_W-1:0]   i_DO = '0;
    logic              i_CORR_EN = 1'b0;
    logic              o_VALID;
    logic              i_READY = 1'b1;
    logic [DATA_W-1:0] o_DO;
    logic              o_SBE;
    logic              o_DBE;
    logic [P_W-1:0]    o_ERR_POS;
    logic              i_CNT_CLR = 1'b0;
    logic [CNT_W-1:0]  o_SBE_CNT;
    logic [CNT_W-1:0]  o_DBE_CNT;

    always #5 i_SCLK = ~i_SCLK;

    ecc_secded_decoder_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_SCLK    (i_SCLK),
        .i_RESETB  (i_RESETB),
        .i_VALID   (i_VALID),
        .o_READY   (o_READY),
        .i_DO      (i_DO),
        .i_CORR_EN (i_CORR_EN),
        .o_VALID   (o_VALID),
        .i_READY   (i_READY),
        .o_DO      (o_DO),
        .o_SBE     (o_SBE),
        .o_DBE     (o_DBE),
        .o_ERR_POS (o_ERR_POS),
        .i_CNT_CLR (i_CNT_CLR),
        .o_SBE_CNT (o_SBE_CNT),
        .o_DBE_CNT (o_DBE_CNT)
    );

    int    checks = 0;
    int    errors = 0;
    int    dpos[DATA_W];
    beat_t in_q[$];
    res_t  exp_q[$];
    res_t  got_q[$];
    int    acc_cyc[$];
    int    out_cyc[$];
    int    unstable;
    int    acc_in_hold;
    bit    timed_out;

    function automatic logic [CW_W-1:0] enc(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        logic            b;
        cw = '0;
        for (int k = 0; k < DATA_W; k++) cw[dpos[k]] = d[k];
        for (int j = 0; j < P_W; j++) begin
            b = 1'b0;
            for (int i = 1; i < CW_W; i++) if (((i >> j) & 1) == 1) b = b ^ cw[i];
            cw[1 << j] = b;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    // Outcome from the set of flipped positions applied to a valid codeword.
    function automatic res_t model(input beat_t bt);
        res_t            r;
        int              s;
        logic            g;
        logic [CW_W-1:0] net;
        s = 0;
        for (int i = 0; i < CW_W; i++) if (bt.mask[i]) s = s ^ i;
        g   = ^bt.mask;
        r.sbe = g && (s <= CW_W - 1);
        r.dbe = (g && (s > CW_W - 1)) || (!g && s != 0);
        r.pos = P_W'(s);
        net   = bt.mask;
        if (r.sbe && bt.corr) net[s] = ~net[s];
        r.data = bt.data;
        for (int k = 0; k < DATA_W; k++) if (net[dpos[k]]) r.data[k] = ~r.data[k];
        return r;
    endfunction

    function automatic logic [CW_W-1:0] bitm(input int p);
        logic [CW_W-1:0] m;
        m = '0;
        m[p] = 1'b1;
        return m;
    endfunction

    function automatic logic [CW_W-1:0] rand_mask(input int n);
        logic [CW_W-1:0] m;
        m = '0;
        while ($countones(m) < n) m[$urandom_range(CW_W - 1)] = 1'b1;
        return m;
    endfunction

    task automatic push(input logic [DATA_W-1:0] d, input logic [CW_W-1:0] m, input logic c);
        beat_t b;
        b.data = d;
        b.mask = m;
        b.corr = c;
        in_q.push_back(b);
    endtask

    task automatic do_reset();
        i_RESETB  = 1'b0;
        i_VALID   = 1'b0;
        i_READY   = 1'b1;
        i_CNT_CLR = 1'b0;
        repeat (2) @(negedge i_SCLK);
        i_RESETB = 1'b1;
    endtask

    // Drives in_q through the handshake and records output beats; drives and samples
    // on the falling edge, transfers are decided 1 ns later once o_READY settles.
    task automatic stream(input int valid_pct, input int ready_pct, input int hold,
                          input int clr_at, input int max_cyc);
        int   n;
        int   sent;
        int   outs;
        int   cyc;
        bit   prev_hold;
        res_t prev;
        res_t cur;
        n = in_q.size();
        sent = 0; outs = 0; cyc = 0; prev_hold = 0; prev = '0;
        exp_q.delete(); got_q.delete(); acc_cyc.delete(); out_cyc.delete();
        unstable = 0; acc_in_hold = 0; timed_out = 0;
        while ((sent < n || got_q.size() < n) && cyc < max_cyc) begin
            @(negedge i_SCLK);
            i_READY = (cyc < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
            if (sent < n && $urandom_range(99) < valid_pct) begin
                i_VALID   = 1'b1;
                i_DO      = enc(in_q[sent].data) ^ in_q[sent].mask;
                i_CORR_EN = in_q[sent].corr;
            end else begin
                i_VALID   = 1'b0;
                i_DO      = CW_W'($urandom);
                i_CORR_EN = 1'($urandom);
            end
            #1;
            cur.data = o_DO; cur.sbe = o_SBE; cur.dbe = o_DBE; cur.pos = o_ERR_POS;
            if (prev_hold && (o_VALID !== 1'b1 || cur !== prev)) unstable++;
            i_CNT_CLR = 1'b0;
            if (o_VALID && i_READY) begin
                if (outs == clr_at) i_CNT_CLR = 1'b1;
                got_q.push_back(cur);
                out_cyc.push_back(cyc);
                outs++;
            end
            prev_hold = o_VALID && !i_READY;
            prev      = cur;
            if (i_VALID && o_READY) begin
                exp_q.push_back(model(in_q[sent]));
                acc_cyc.push_back(cyc);
                if (cyc < hold) acc_in_hold++;
                sent++;
            end
            cyc++;
        end
        if (cyc >= max_cyc) timed_out = 1;
        @(negedge i_SCLK);
        i_VALID = 1'b0; i_READY = 1'b1; i_CNT_CLR = 1'b0;
        #1;
        in_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({o_VALID, o_DO, o_SBE, o_DBE, o_ERR_POS} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b do=%h sbe=%b dbe=%b pos=%0d exp all 0",
                     o_VALID, o_DO, o_SBE, o_DBE, o_ERR_POS);
        end
        checks++;
        if (o_SBE_CNT !== 0 || o_DBE_CNT !== 0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d exp 0/0", o_SBE_CNT, o_DBE_CNT);
        end
        checks++;
        if (o_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", o_READY);
        end
    endtask

    task automatic test_clean();
        do_reset();
        push(16'hA5C3, '0, 1'b1);
        push(16'h0000, '0, 1'b1);
        push(16'hFFFF, '0, 1'b0);
        stream(100, 100, 0, -1, 40);
        checks++;
        if (timed_out !== 1'b0 || got_q.size() != 3) begin
            errors++;
            $display("FAIL clean_count got %0d beats timeout=%b exp 3", got_q.size(), timed_out);
        end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_q[i].sbe || got_q[i].dbe) begin
                errors++;
                $display("FAIL clean_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
            checks++;
            if (out_cyc[i] - acc_cyc[i] != 2) begin
                errors++;
                $display("FAIL clean_latency%0d got %0d exp 2", i, out_cyc[i] - acc_cyc[i]);
            end
        end
        checks++;
        if (o_SBE_CNT !== 0 || o_DBE_CNT !== 0) begin
            errors++;
            $display("FAIL clean_counters got %0d/%0d exp 0/0", o_SBE_CNT, o_DBE_CNT);
        end
    endtask

    task automatic test_single();
        res_t want[3];
        int   wcnt[3];
        logic [CW_W-1:0] m[3];
        logic c[3];
        want[0] = res_t'{data:16'hA5C3, sbe:1'b1, dbe:1'b0, pos:5'd5}; m[0] = bitm(5); c[0] = 1'b1;
        want[1] = res_t'{data:16'hA5C1, sbe:1'b1, dbe:1'b0, pos:5'd5}; m[1] = bitm(5); c[1] = 1'b0;
        want[2] = res_t'{data:16'hA5C3, sbe:1'b1, dbe:1'b0, pos:5'd0}; m[2] = bitm(0); c[2] = 1'b1;
        wcnt[0] = 1; wcnt[1] = 2; wcnt[2] = 3;
        do_reset();
        for (int t = 0; t < 3; t++) begin
            push(16'hA5C3, m[t], c[t]);
            stream(100, 100, 0, -1, 20);
            checks++;
            if (got_q.size() != 1 || got_q[0] !== want[t]) begin
                errors++;
                $display("FAIL single%0d got %h (n=%0d) exp %h", t,
                         got_q.size() ? got_q[0] : '0, got_q.size(), want[t]);
            end
            checks++;
            if (o_SBE_CNT !== CNT_W'(wcnt[t]) || o_DBE_CNT !== 0) begin
                errors++;
                $display("FAIL single%0d_cnt got %0d/%0d exp %0d/0", t, o_SBE_CNT, o_DBE_CNT, wcnt[t]);
            end
        end
    endtask

    task automatic test_double();
        res_t want[2];
        logic [CW_W-1:0] m[2];
        want[0] = res_t'{data:16'hA5D2, sbe:1'b0, dbe:1'b1, pos:5'd10};
        m[0]    = bitm(3) | bitm(9);
        want[1] = res_t'{data:16'hA5C3, sbe:1'b0, dbe:1'b1, pos:5'd22};
        m[1]    = bitm(2) | bitm(4) | bitm(16);
        do_reset();
        for (int t = 0; t < 2; t++) begin
            push(16'hA5C3, m[t], 1'b1);
            stream(100, 100, 0, -1, 20);
            checks++;
            if (got_q.size() != 1 || got_q[0] !== want[t]) begin
                errors++;
                $display("FAIL double%0d got %h (n=%0d) exp %h", t,
                         got_q.size() ? got_q[0] : '0, got_q.size(), want[t]);
            end
            checks++;
            if (o_DBE_CNT !== CNT_W'(t + 1) || o_SBE_CNT !== 0) begin
                errors++;
                $display("FAIL double%0d_cnt got %0d/%0d exp 0/%0d", t, o_SBE_CNT, o_DBE_CNT, t + 1);
            end
        end
    endtask

    task automatic test_random();
        int nsbe;
        int ndbe;
        int bad;
        do_reset();
        for (int i = 0; i < 300; i++)
            push(DATA_W'($urandom), rand_mask($urandom_range(3)), 1'($urandom));
        stream(80, 70, 0, -1, 3000);
        checks++;
        if (timed_out !== 1'b0 || got_q.size() != exp_q.size() || got_q.size() != 300) begin
            errors++;
            $display("FAIL random_count got %0d exp %0d timeout=%b", got_q.size(), 300, timed_out);
        end
        bad = 0; nsbe = 0; ndbe = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (exp_q[i].sbe) nsbe++;
            if (exp_q[i].dbe) ndbe++;
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                if (bad < 5) $display("FAIL random_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
                bad++;
            end
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL random_stable got %0d changes exp 0", unstable);
        end
        checks++;
        if (o_SBE_CNT !== CNT_W'(nsbe > 15 ? 15 : nsbe) || o_DBE_CNT !== CNT_W'(ndbe > 15 ? 15 : ndbe)) begin
            errors++;
            $display("FAIL random_cnt got %0d/%0d exp %0d/%0d", o_SBE_CNT, o_DBE_CNT,
                     nsbe > 15 ? 15 : nsbe, ndbe > 15 ? 15 : ndbe);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 6; i++) push(DATA_W'($urandom), rand_mask($urandom_range(2)), 1'($urandom));
        stream(100, 100, 5, -1, 60);
        checks++;
        if (acc_in_hold != 2) begin
            errors++;
            $display("FAIL bp_accepted got %0d exp 2", acc_in_hold);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL bp_stable got %0d changes exp 0", unstable);
        end
        checks++;
        if (timed_out !== 1'b0 || got_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count got %0d exp 6 timeout=%b", got_q.size(), timed_out);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_sat_clear();
        do_reset();
        for (int i = 0; i < 17; i++) push(DATA_W'($urandom), rand_mask(1), 1'($urandom));
        stream(100, 100, 0, -1, 80);
        checks++;
        if (o_SBE_CNT !== 4'd15 || got_q.size() != 17) begin
            errors++;
            $display("FAIL sat_cnt got %0d (n=%0d) exp 15", o_SBE_CNT, got_q.size());
        end
        push(16'h1234, bitm(7), 1'b1);
        stream(100, 100, 0, 0, 20);
        checks++;
        if (got_q.size() != 1 || got_q[0].sbe !== 1'b1) begin
            errors++;
            $display("FAIL clr_beat got n=%0d sbe=%b exp 1/1", got_q.size(), got_q.size() ? got_q[0].sbe : 1'b0);
        end
        checks++;
        if (o_SBE_CNT !== 0) begin
            errors++;
            $display("FAIL clr_cnt got %0d exp 0", o_SBE_CNT);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) push(DATA_W'($urandom), rand_mask(1), 1'b1);
        stream(100, 100, 0, -1, 30);
        @(negedge i_SCLK);
        i_VALID = 1'b1; i_DO = enc(16'h0F0F); i_CORR_EN = 1'b1;
        @(negedge i_SCLK);
        i_DO = enc(16'hF0F0);
        @(negedge i_SCLK);
        i_VALID = 1'b0;
        #1;
        checks++;
        if (o_VALID !== 1'b1 || o_SBE_CNT !== 4'd3) begin
            errors++;
            $display("FAIL mid_pre got v=%b cnt=%0d exp 1/3", o_VALID, o_SBE_CNT);
        end
        #1 i_RESETB = 1'b0;
        #1;
        checks++;
        if (o_VALID !== 1'b0 || o_DO !== 0 || o_SBE_CNT !== 0 || o_DBE_CNT !== 0) begin
            errors++;
            $display("FAIL mid_reset got v=%b do=%h cnt=%0d/%0d exp 0", o_VALID, o_DO, o_SBE_CNT, o_DBE_CNT);
        end
        @(negedge i_SCLK);
        i_RESETB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_SCLK);
            #1;
            checks++;
            if (o_VALID !== 1'b0 || o_READY !== 1'b1) begin
                errors++;
                $display("FAIL mid_after%0d got v=%b rdy=%b exp 0/1", i, o_VALID, o_READY);
            end
        end
    endtask

    initial begin
        int p;
        p = 3;
        for (int k = 0; k < DATA_W; k++) begin
            while ((p & (p - 1)) == 0) p++;
            dpos[k] = p;
            p++;
        end
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_backpressure();
        test_random();
        test_sat_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
